// File: rtl/serial_rx_fifo.sv
// serial_rx_fifo: receive-side byte buffer between the serial receiver and an
// FSL master port. Each rising edge of rx_have_data_i captures one byte into a
// first-word-fall-through FIFO; the head byte is offered on an exists/read
// handshake.
//
// Ports:
//   clock          system clock, all state updates on the rising edge
//   reset          asynchronous active-low reset
//   rx_data_i      byte from the serial receiver
//   rx_have_data_i receiver data-exists level; a rising edge marks a new byte
//   fsl_data_o     registered head-of-FIFO byte, valid while fsl_exists_o is high
//   fsl_exists_o   FIFO not empty
//   fsl_read_i     pop the head byte this cycle (ignored while empty)
//   rs232_cts_o    clear-to-send toward the remote device, with hysteresis
//   overrun_o      sticky flag: a byte arrived while the FIFO was full
//   overrun_clr_i  clears overrun_o (a simultaneous overrun wins)
//   count_o        current fill count, 0..DEPTH
module serial_rx_fifo #(
  parameter int unsigned DEPTH_LOG2    = 4,
  parameter int unsigned CTS_OFF_LEVEL = 12,
  parameter int unsigned CTS_ON_LEVEL  = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_have_data_i,
  output logic [7:0]            fsl_data_o,
  output logic                  fsl_exists_o,
  input  logic                  fsl_read_i,
  output logic                  rs232_cts_o,
  output logic                  overrun_o,
  input  logic                  overrun_clr_i,
  output logic [DEPTH_LOG2:0]   count_o
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;

  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CTS_OFF_CNT = CNT_W'(CTS_OFF_LEVEL);
  localparam logic [CNT_W-1:0] CTS_ON_CNT  = CNT_W'(CTS_ON_LEVEL);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic             have_q;

  logic             wr_req_c;
  logic             rd_acc_c;
  logic             wr_acc_c;
  logic             drop_c;
  logic [CNT_W-1:0] cnt_after_rd_c;
  logic [CNT_W-1:0] count_nxt_c;
  logic [PTR_W-1:0] rd_ptr_nxt_c;
  logic [7:0]       data_nxt_c;
  logic             cts_nxt_c;

  // Handshake decode: a full FIFO still accepts a write if a read frees a slot
  always_comb begin
    wr_req_c       = rx_have_data_i & ~have_q;
    rd_acc_c       = fsl_read_i & fsl_exists_o;
    wr_acc_c       = wr_req_c & ((count_o != FULL_CNT) | rd_acc_c);
    drop_c         = wr_req_c & ~wr_acc_c;
    cnt_after_rd_c = count_o - CNT_W'(rd_acc_c);
    count_nxt_c    = cnt_after_rd_c + CNT_W'(wr_acc_c);
    rd_ptr_nxt_c   = rd_ptr_q + PTR_W'(rd_acc_c);
  end

  // Next head byte: stored entry if one survives the read, else bypass the
  // incoming byte straight into the output register
  always_comb begin
    data_nxt_c = fsl_data_o;
    if (cnt_after_rd_c != '0) begin
      data_nxt_c = mem[rd_ptr_nxt_c];
    end else if (wr_acc_c) begin
      data_nxt_c = rx_data_i;
    end
  end

  // CTS hysteresis on the post-update count
  always_comb begin
    cts_nxt_c = rs232_cts_o;
    if (rs232_cts_o && (count_nxt_c >= CTS_OFF_CNT)) begin
      cts_nxt_c = 1'b0;
    end else if (!rs232_cts_o && (count_nxt_c <= CTS_ON_CNT)) begin
      cts_nxt_c = 1'b1;
    end
  end

  // Storage array, no reset on contents
  always_ff @(posedge clock) begin
    if (wr_acc_c) begin
      mem[wr_ptr_q] <= rx_data_i;
    end
  end

  // Control and output registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      have_q       <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_o      <= '0;
      fsl_exists_o <= 1'b0;
      fsl_data_o   <= 8'h00;
      rs232_cts_o  <= 1'b1;
      overrun_o    <= 1'b0;
    end else begin
      have_q       <= rx_have_data_i;
      rd_ptr_q     <= rd_ptr_nxt_c;
      wr_ptr_q     <= wr_ptr_q + PTR_W'(wr_acc_c);
      count_o      <= count_nxt_c;
      fsl_exists_o <= (count_nxt_c != '0);
      fsl_data_o   <= data_nxt_c;
      rs232_cts_o  <= cts_nxt_c;
      if (drop_c) begin
        overrun_o <= 1'b1;
      end else if (overrun_clr_i) begin
        overrun_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_rx_fifo.sv
// Directed bench for serial_rx_fifo. Inputs change 1 time unit after a rising
// edge; outputs are checked at that same point, i.e. after the edge settled.
module tb_serial_rx_fifo;

  logic       clock;
  logic       reset;
  logic [7:0] rx_data_i;
  logic       rx_have_data_i;
  logic [7:0] fsl_data_o;
  logic       fsl_exists_o;
  logic       fsl_read_i;
  logic       rs232_cts_o;
  logic       overrun_o;
  logic       overrun_clr_i;
  logic [4:0] count_o;

  int n_cmp;
  int n_err;

  serial_rx_fifo #(
    .DEPTH_LOG2   (4),
    .CTS_OFF_LEVEL(12),
    .CTS_ON_LEVEL (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .rx_data_i     (rx_data_i),
    .rx_have_data_i(rx_have_data_i),
    .fsl_data_o    (fsl_data_o),
    .fsl_exists_o  (fsl_exists_o),
    .fsl_read_i    (fsl_read_i),
    .rs232_cts_o   (rs232_cts_o),
    .overrun_o     (overrun_o),
    .overrun_clr_i (overrun_clr_i),
    .count_o       (count_o)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One receiver byte: one high cycle (the write edge) then one low cycle
  task automatic send_byte(input logic [7:0] b);
    rx_data_i      = b;
    rx_have_data_i = 1'b1;
    tick();
    rx_have_data_i = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rx_have_data_i = i[0];
      rx_data_i      = 8'(i * 17);
      fsl_read_i     = ~i[0];
      overrun_clr_i  = i[1];
      tick();
    end
    n_cmp++;
    if (count_o !== 5'd0 || fsl_exists_o !== 1'b0 || rs232_cts_o !== 1'b1 || overrun_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: cnt=%0d ex=%b cts=%b ovr=%b, want 0/0/1/0", count_o, fsl_exists_o, rs232_cts_o, overrun_o);
    end
    rx_have_data_i = 1'b0;
    fsl_read_i     = 1'b0;
    overrun_clr_i  = 1'b0;
    reset          = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (count_o !== 5'd0 || fsl_exists_o !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: cnt=%0d ex=%b, want 0/0", count_o, fsl_exists_o);
    end
  endtask

  task automatic test_single();
    rx_data_i      = 8'hAB;
    rx_have_data_i = 1'b1;
    tick();
    n_cmp++;
    if (fsl_exists_o !== 1'b1 || fsl_data_o !== 8'hAB || count_o !== 5'd1) begin
      n_err++;
      $display("FAIL single_write: ex=%b data=%h cnt=%0d, want 1/ab/1", fsl_exists_o, fsl_data_o, count_o);
    end
    tick();
    tick();
    n_cmp++;
    if (count_o !== 5'd1) begin
      n_err++;
      $display("FAIL single_level_hold: cnt=%0d, want 1", count_o);
    end
    rx_have_data_i = 1'b0;
    tick();
    fsl_read_i = 1'b1;
    tick();
    fsl_read_i = 1'b0;
    n_cmp++;
    if (fsl_exists_o !== 1'b0 || count_o !== 5'd0) begin
      n_err++;
      $display("FAIL single_read: ex=%b cnt=%0d, want 0/0", fsl_exists_o, count_o);
    end
  endtask

  task automatic test_order_wrap();
    for (int i = 0; i < 40; i++) begin
      rx_data_i      = 8'(i);
      rx_have_data_i = 1'b1;
      tick();
      rx_have_data_i = 1'b0;
      fsl_read_i     = 1'b1;
      n_cmp++;
      if (fsl_exists_o !== 1'b1 || fsl_data_o !== 8'(i) || count_o !== 5'd1) begin
        n_err++;
        $display("FAIL wrap_head[%0d]: ex=%b data=%h cnt=%0d, want 1/%h/1", i, fsl_exists_o, fsl_data_o, count_o, 8'(i));
      end
      tick();
      fsl_read_i = 1'b0;
      n_cmp++;
      if (count_o !== 5'd0 || fsl_exists_o !== 1'b0) begin
        n_err++;
        $display("FAIL wrap_drain[%0d]: cnt=%0d ex=%b, want 0/0", i, count_o, fsl_exists_o);
      end
    end
  endtask

  // Leaves the FIFO full with 8'h88..8'h8F, 8'h90..8'h97 (head 8'h88)
  task automatic test_fill_cts();
    for (int i = 0; i < 12; i++) begin
      send_byte(8'h80 + 8'(i));
      if (i == 10) begin
        n_cmp++;
        if (rs232_cts_o !== 1'b1 || count_o !== 5'd11) begin
          n_err++;
          $display("FAIL cts_at_11: cts=%b cnt=%0d, want 1/11", rs232_cts_o, count_o);
        end
      end
    end
    n_cmp++;
    if (rs232_cts_o !== 1'b0 || count_o !== 5'd12) begin
      n_err++;
      $display("FAIL cts_at_12: cts=%b cnt=%0d, want 0/12", rs232_cts_o, count_o);
    end
    for (int i = 12; i < 16; i++) send_byte(8'h80 + 8'(i));
    n_cmp++;
    if (count_o !== 5'd16 || rs232_cts_o !== 1'b0) begin
      n_err++;
      $display("FAIL full_16: cnt=%0d cts=%b, want 16/0", count_o, rs232_cts_o);
    end
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if (fsl_data_o !== 8'h80 + 8'(i)) begin
        n_err++;
        $display("FAIL fill_order[%0d]: data=%h, want %h", i, fsl_data_o, 8'h80 + 8'(i));
      end
      fsl_read_i = 1'b1;
      tick();
      fsl_read_i = 1'b0;
    end
    n_cmp++;
    if (count_o !== 5'd9 || rs232_cts_o !== 1'b0) begin
      n_err++;
      $display("FAIL cts_at_9: cnt=%0d cts=%b, want 9/0", count_o, rs232_cts_o);
    end
    fsl_read_i = 1'b1;
    tick();
    fsl_read_i = 1'b0;
    n_cmp++;
    if (count_o !== 5'd8 || rs232_cts_o !== 1'b1) begin
      n_err++;
      $display("FAIL cts_at_8: cnt=%0d cts=%b, want 8/1", count_o, rs232_cts_o);
    end
    for (int i = 0; i < 8; i++) send_byte(8'h90 + 8'(i));
    n_cmp++;
    if (count_o !== 5'd16 || fsl_data_o !== 8'h88 || rs232_cts_o !== 1'b0) begin
      n_err++;
      $display("FAIL refill: cnt=%0d data=%h cts=%b, want 16/88/0", count_o, fsl_data_o, rs232_cts_o);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] exp_q [$];
    send_byte(8'h55);
    n_cmp++;
    if (overrun_o !== 1'b1 || count_o !== 5'd16 || fsl_data_o !== 8'h88) begin
      n_err++;
      $display("FAIL overrun_drop: ovr=%b cnt=%0d data=%h, want 1/16/88", overrun_o, count_o, fsl_data_o);
    end
    // Clear racing a second drop: set must win
    rx_data_i      = 8'h77;
    rx_have_data_i = 1'b1;
    overrun_clr_i  = 1'b1;
    tick();
    rx_have_data_i = 1'b0;
    overrun_clr_i  = 1'b0;
    n_cmp++;
    if (overrun_o !== 1'b1 || count_o !== 5'd16) begin
      n_err++;
      $display("FAIL overrun_set_wins: ovr=%b cnt=%0d, want 1/16", overrun_o, count_o);
    end
    tick();
    // Write into a full FIFO alongside a read
    rx_data_i      = 8'h66;
    rx_have_data_i = 1'b1;
    fsl_read_i     = 1'b1;
    tick();
    rx_have_data_i = 1'b0;
    fsl_read_i     = 1'b0;
    n_cmp++;
    if (count_o !== 5'd16 || fsl_data_o !== 8'h89) begin
      n_err++;
      $display("FAIL full_rd_wr: cnt=%0d data=%h, want 16/89", count_o, fsl_data_o);
    end
    for (int i = 9; i < 16; i++) exp_q.push_back(8'h80 + 8'(i));
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h90 + 8'(i));
    exp_q.push_back(8'h66);
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (fsl_exists_o !== 1'b1 || fsl_data_o !== exp_q[i]) begin
        n_err++;
        $display("FAIL drain[%0d]: ex=%b data=%h, want 1/%h", i, fsl_exists_o, fsl_data_o, exp_q[i]);
      end
      fsl_read_i = 1'b1;
      tick();
      fsl_read_i = 1'b0;
    end
    n_cmp++;
    if (fsl_exists_o !== 1'b0 || count_o !== 5'd0 || overrun_o !== 1'b1) begin
      n_err++;
      $display("FAIL drained: ex=%b cnt=%0d ovr=%b, want 0/0/1", fsl_exists_o, count_o, overrun_o);
    end
    overrun_clr_i = 1'b1;
    tick();
    overrun_clr_i = 1'b0;
    n_cmp++;
    if (overrun_o !== 1'b0) begin
      n_err++;
      $display("FAIL overrun_clear: ovr=%b, want 0", overrun_o);
    end
  endtask

  task automatic test_edge_cases();
    fsl_read_i = 1'b1;
    tick();
    tick();
    fsl_read_i = 1'b0;
    n_cmp++;
    if (count_o !== 5'd0 || fsl_exists_o !== 1'b0) begin
      n_err++;
      $display("FAIL read_empty: cnt=%0d ex=%b, want 0/0", count_o, fsl_exists_o);
    end
    rx_data_i      = 8'h3C;
    rx_have_data_i = 1'b1;
    fsl_read_i     = 1'b1;
    tick();
    rx_have_data_i = 1'b0;
    fsl_read_i     = 1'b0;
    n_cmp++;
    if (count_o !== 5'd1 || fsl_exists_o !== 1'b1 || fsl_data_o !== 8'h3C) begin
      n_err++;
      $display("FAIL write_empty_read: cnt=%0d ex=%b data=%h, want 1/1/3c", count_o, fsl_exists_o, fsl_data_o);
    end
    fsl_read_i = 1'b1;
    tick();
    fsl_read_i = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(8'hC0 + 8'(i));
    n_cmp++;
    if (count_o !== 5'd5 || fsl_data_o !== 8'hC0) begin
      n_err++;
      $display("FAIL pre_reset_fill: cnt=%0d data=%h, want 5/c0", count_o, fsl_data_o);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (count_o !== 5'd0 || fsl_exists_o !== 1'b0 || rs232_cts_o !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset: cnt=%0d ex=%b cts=%b, want 0/0/1", count_o, fsl_exists_o, rs232_cts_o);
    end
    tick();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (count_o !== 5'd0 || fsl_exists_o !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_empty: cnt=%0d ex=%b, want 0/0", count_o, fsl_exists_o);
    end
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    reset          = 1'b0;
    rx_data_i      = 8'h00;
    rx_have_data_i = 1'b0;
    fsl_read_i     = 1'b0;
    overrun_clr_i  = 1'b0;
    #1;
    test_reset();
    test_single();
    test_order_wrap();
    test_fill_cts();
    test_overrun();
    test_edge_cases();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_rx_fifo.md
Name: serial_rx_fifo

Overview:
Receive-side buffer between the serial receiver (parallel byte + have-data line) and the FSL master port toward the processor. It captures each received byte on the rising edge of the receiver's have-data line and stores it in a first-word-fall-through FIFO. It presents stored bytes on an FSL-style exists/read handshake. It drives the RS-232 CTS line from FIFO fill level and latches a sticky overrun flag when a byte arrives while the FIFO is full.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 2**DEPTH_LOG2 = 16 bytes)
CTS_OFF_LEVEL, 12, fill count at or above which rs232_cts_o deasserts
CTS_ON_LEVEL, 8, fill count at or below which rs232_cts_o reasserts (must be < CTS_OFF_LEVEL)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
rx_data_i  input  8  byte from serial receiver, valid while rx_have_data_i high
rx_have_data_i  input  1  receiver data-exists line (level); rising edge = new byte
fsl_data_o  output  8  head-of-FIFO byte (FWFT), valid when fsl_exists_o high
fsl_exists_o  output  1  FIFO not empty
fsl_read_i  input  1  consumer pops head byte this cycle (ignored when empty)
rs232_cts_o  output  1  clear-to-send toward remote device, hysteretic
overrun_o  output  1  sticky: a byte was dropped because FIFO was full
overrun_clr_i  input  1  clears overrun_o
count_o  output  DEPTH_LOG2+1  current fill count, 0..DEPTH

Behaviour:
- Reset (reset low, async assert, sync release): pointers = 0, count_o = 0, fsl_exists_o = 0, fsl_data_o = 8'h00, rs232_cts_o = 1, overrun_o = 0, edge-detect register = 0. A reset mid-operation discards all stored bytes.
- Edge detect: register rx_have_data_i every cycle. wr_req = rx_have_data_i & ~prev. A level held high for N cycles produces exactly one write. A byte is sampled from rx_data_i in the same cycle as wr_req.
- Write: accepted if count < DEPTH, or if count == DEPTH and a read is accepted in the same cycle. Otherwise the byte is dropped and overrun_o is set on the next edge.
- Read: accepted iff fsl_read_i & fsl_exists_o. fsl_read_i while empty has no effect (no underflow, pointer unchanged).
- Simultaneous accepted read + write: count unchanged, both pointers advance.
- Write into empty FIFO with fsl_read_i high in the same cycle: read is ignored (exists was 0). The byte becomes visible the next cycle.
- Latency: byte written at edge k → fsl_exists_o = 1 and fsl_data_o = byte after edge k (visible in cycle k+1). Read at edge k → next byte (or exists = 0) after edge k.
- fsl_data_o is registered. It holds the last value when the FIFO is empty. Contents are don't-care and must not be checked while exists = 0.
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. count_o is tracked separately with DEPTH_LOG2+1 bits and never exceeds DEPTH or goes below 0.
- rs232_cts_o is registered, computed from the post-update count:
  - 1 → 0 when count >= CTS_OFF_LEVEL.
  - 0 → 1 when count <= CTS_ON_LEVEL.
  - Otherwise holds.
- overrun_o: set on a dropped write, cleared by overrun_clr_i. If both happen in the same cycle, set wins.
- Storage: DEPTH x 8 register array, synchronous write, no reset required on array contents.

Test Plan:
- Reset/idle: hold reset = 0 with inputs toggling → count_o = 0, fsl_exists_o = 0, rs232_cts_o = 1, overrun_o = 0. Release reset → no spurious write.
- Single byte: pulse rx_have_data_i high 3 cycles with rx_data_i = 8'hAB → exactly one entry. Next cycle fsl_exists_o = 1, fsl_data_o = 8'hAB, count_o = 1. Assert fsl_read_i one cycle → exists = 0, count_o = 0.
- Order and wrap: write 8'h00..8'h27 (40 bytes) while reading continuously one cycle after each write → all 40 bytes read back in order, count_o never > 1, pointers wrap twice.
- Fill and CTS hysteresis: write 12 bytes without reading → rs232_cts_o = 0 after the 12th write. Write 4 more → count_o = 16. Read 7 → cts still 0 at count 9. Read 1 more → cts = 1 at count 8.
- Overrun: with 16 stored, write 8'h55 → dropped, overrun_o = 1, count_o = 16, head unchanged. Write 8'h66 simultaneously with a read → accepted, count stays 16, 8'h66 is the last byte out. Assert overrun_clr_i → overrun_o = 0.
- Edge cases: fsl_read_i = 1 while empty → no change. Write into empty with fsl_read_i = 1 same cycle → count_o = 1 next cycle. Assert reset low mid-fill (count 5) → count_o = 0, exists = 0 immediately (async).
